// File: rtl/gf_2m_div.sv
// Sequential GF(2^m) divider y = a * b^-1 mod p, inverse via Fermat exponentiation b^(2^m-2).
// Optional divide-by-zero flag enabled by defining GF_DIV_ZERO_CHECK_EN.

module gf_2m_mul #(
    parameter int m = 4
) (
    input  logic [m-1:0] a,
    input  logic [m-1:0] b,
    input  logic [m-1:0] p,
    output logic [m-1:0] y
);
    logic [m-1:0] acc;

    // Horner form, MSB of b first: shift, fold x^m back through p, add a.
    always_comb begin
        acc = '0;
        for (int i = m - 1; i >= 0; i--) begin
            acc = {acc[m-2:0], 1'b0} ^ (acc[m-1] ? p : '0);
            if (b[i]) begin
                acc = acc ^ a;
            end
        end
        y = acc;
    end
endmodule

module gf_2m_div #(
    parameter int m = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [m-1:0] a,
    input  logic [m-1:0] b,
    input  logic [m-1:0] p,
    output logic         busy,
    output logic         done,
    output logic [m-1:0] y,
    output logic         err
);
    localparam int CW = (m <= 2) ? 1 : $clog2(m);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [m-1:0]  r_q, r_d;
    logic [m-1:0]  sq_q, sq_d;
    logic [m-1:0]  pr_q, pr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [m-1:0]  y_q, y_d;
    logic [m-1:0]  sq_n;
    logic [m-1:0]  r_n;
    logic          load;

    gf_2m_mul #(.m(m)) u_square (
        .a (sq_q),
        .b (sq_q),
        .p (pr_q),
        .y (sq_n)
    );

    // Chained on the fresh square so r picks up b^(2^(k+1)) in the same cycle.
    gf_2m_mul #(.m(m)) u_accum (
        .a (r_q),
        .b (sq_n),
        .p (pr_q),
        .y (r_n)
    );

`ifdef GF_DIV_ZERO_CHECK_EN
    logic zf_q, zf_d;
    logic err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        sq_d    = sq_q;
        pr_d    = pr_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        busy    = 1'b0;
        done    = 1'b0;
        load    = 1'b0;
`ifdef GF_DIV_ZERO_CHECK_EN
        zf_d    = zf_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                load = start;
            end
            RUN: begin
                busy  = 1'b1;
                sq_d  = sq_n;
                r_d   = r_n;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
`ifdef GF_DIV_ZERO_CHECK_EN
                    y_d     = zf_q ? '0 : r_n;
                    err_d   = zf_q;
`else
                    y_d     = r_n;
`endif
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
                load    = start;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            state_d = RUN;
            r_d     = a;
            sq_d    = b;
            pr_d    = p;
            cnt_d   = CW'(m - 1);
`ifdef GF_DIV_ZERO_CHECK_EN
            zf_d    = (b == '0);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            sq_q    <= '0;
            pr_q    <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            sq_q    <= sq_d;
            pr_q    <= pr_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

`ifdef GF_DIV_ZERO_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zf_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            zf_q  <= zf_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign y = y_q;

endmodule

// File: tb/tb_gf_2m_div.sv
// Scoreboard bench for gf_2m_div (m=4, p=x^4+x+1) against a polynomial-arithmetic reference.
module tb_gf_2m_div;
    localparam int M = 4;
    localparam logic [3:0] P = 4'b0011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic [3:0] p = P;
    logic       busy, done, err;
    logic [3:0] y;

    always #5 clk = ~clk;

    gf_2m_div #(.m(M)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .p     (p),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .err   (err)
    );

`ifdef GF_DIV_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] y;
        logic       err;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: carry-less product then long division by the full x^4 + p.
    function automatic logic [3:0] ref_mul(input logic [3:0] x, input logic [3:0] z);
        logic [7:0] prod;
        logic [7:0] poly;
        prod = '0;
        poly = {3'b000, 1'b1, P};
        for (int i = 0; i < 4; i++)
            if (z[i]) prod = prod ^ ({4'b0000, x} << i);
        for (int i = 7; i >= 4; i--)
            if (prod[i]) prod = prod ^ (poly << (i - 4));
        return prod[3:0];
    endfunction

    function automatic logic [3:0] ref_div(input logic [3:0] x, input logic [3:0] z);
        logic [3:0] inv;
        inv = '0;
        if (z == 4'd0) return 4'd0;
        for (int v = 1; v < 16; v++)
            if (ref_mul(z, 4'(v)) == 4'd1) inv = 4'(v);
        return ref_mul(x, inv);
    endfunction

    task automatic push_exp(input logic [3:0] ea, input logic [3:0] eb,
                            input logic [3:0] ey, input logic ee);
        exp_t e;
        e.a = ea; e.b = eb; e.y = ey; e.err = ee; e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("idle_timeout", busy, 0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("drain_timeout", sb.size(), 0);
    endtask

    task automatic issue(input logic [3:0] ia, input logic [3:0] ib,
                         input logic [3:0] ey, input logic ee, input bit push);
        wait_idle();
        a = ia; b = ib; p = P; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) push_exp(ia, ib, ey, ee);
        a = 4'($urandom); b = 4'($urandom); p = 4'($urandom);
    endtask

    task automatic issue_ref(input logic [3:0] ia, input logic [3:0] ib);
        issue(ia, ib, ref_div(ia, ib), ZC && (ib == 4'd0), 1'b1);
    endtask

    // Monitor: pops on every done, and watches y/err stay put otherwise.
    logic [3:0] y_prev = '0;
    logic       err_prev = 1'b0;
    exp_t       mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (done === 1'b1) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        mon_e = sb.pop_front();
                        check("y", y, mon_e.y);
                        check("err", err, mon_e.err);
                        check("latency", cyc - mon_e.acc, M - 1);
                        if (mon_e.b != 4'd0) check("y_times_b", ref_mul(y, mon_e.b), mon_e.a);
                    end
                end else begin
                    check("y_stable", y, y_prev);
                    check("err_stable", err, err_prev);
                end
            end
            y_prev = y;
            err_prev = err;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        int prev;
        logic [3:0] ra, rb;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_y", y, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        issue(4'd1, 4'd2, 4'd9, 1'b0, 1'b1);
        issue(4'd1, 4'd3, 4'd14, 1'b0, 1'b1);
        issue(4'd5, 4'd5, 4'd1, 1'b0, 1'b1);
        issue(4'd7, 4'd1, 4'd7, 1'b0, 1'b1);
        issue(4'd0, 4'd9, 4'd0, 1'b0, 1'b1);

        // Divide by zero, then a clean operation clears err.
        issue(4'd6, 4'd0, 4'd0, ZC, 1'b1);
        issue(4'd2, 4'd2, 4'd1, 1'b0, 1'b1);

        // Start pulsed while busy must be ignored.
        issue(4'd1, 4'd2, 4'd9, 1'b0, 1'b1);
        a = 4'd3; b = 4'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain();

        for (int ia = 0; ia < 16; ia++)
            for (int ib = 1; ib < 16; ib++)
                issue_ref(4'(ia), 4'(ib));
        wait_drain();

        // Start held high: one acceptance every M cycles.
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_idle();
            ra = 4'($urandom);
            rb = 4'($urandom_range(1, 15));
            a = ra; b = rb; p = P; start = 1'b1;
            @(posedge clk);
            #1;
            push_exp(ra, rb, ref_div(ra, rb), 1'b0);
            if (k > 0) check("b2b_period", cyc - prev, M);
            prev = cyc;
        end
        start = 1'b0;
        wait_drain();

        for (int k = 0; k < 40; k++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            issue_ref(ra, rb);
        end
        wait_drain();

        // Reset mid-RUN aborts with no done pulse.
        issue(4'd1, 4'd3, 4'd14, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_y", y, 0);
        check("midrst_err", err, 0);
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_done", done, 0);
        end
        rst = 1'b0;
        repeat (8) @(negedge clk);

        issue(4'd2, 4'd2, 4'd1, 1'b0, 1'b1);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
